instr_register_alu: RTL
=======================

# instr_register_alu

Parametrised instruction register with a built-in result unit, successor to the fixed 32-entry instruction register used in the lab testbench flow. Each write captures opcode and two signed operands, computes the result in a one-stage pipeline, and commits {opcode, operands, result, error} into a DEPTH-entry register file with per-entry valid bits. Reads are registered and bypass an in-flight commit. The DUT is driven directly by the lab testbenches.

## Interface
- OP_W, 32, signed operand width in bits (>= 2)
- DEPTH, 32, number of register entries (2..256; need not be a power of 2)
- AW, $clog2(DEPTH), pointer width (derived; do not override)

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_en  in  1  write request, sampled at posedge
- clear_en  in  1  synchronous clear of all valid bits
- opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
- operand_a  in  OP_W  signed operand A
- operand_b  in  OP_W  signed operand B
- write_pointer  in  AW  write address
- read_pointer  in  AW  read address
- rd_opcode  out  3  opcode of entry read
- rd_op_a  out  OP_W  operand A of entry read
- rd_op_b  out  OP_W  operand B of entry read
- rd_result  out  2*OP_W  signed result of entry read
- rd_err  out  1  divide-by-zero flag of entry read
- rd_valid  out  1  entry read has been written since last clear/reset
- count  out  AW+1  number of valid entries

## Operation
- Stage 1 (S1): at posedge with load_en=1 and write_pointer < DEPTH, capture opcode, operands, pointer; s1_vld<=1. Otherwise s1_vld<=0. Out-of-range write is dropped silently.
- Commit: at the next posedge with s1_vld=1, entry[ptr] <= {opc, a, b, result, err}; valid[ptr]<=1. Commit happens regardless of load_en that cycle (back-to-back writes: one per cycle, no stall).
- Result from S1 registers, operands sign-extended to 2*OP_W: ZERO->0; PASSA->a; PASSB->b; ADD a+b; SUB a-b; MULT full signed a*b; DIV a/b truncated toward zero; MOD a%b, sign follows a. No overflow possible at 2*OP_W (incl. min/-1). DIV or MOD with b=0: result 0, err=1; all other cases err=0.
- Read: every posedge, rd_* <= entry[read_pointer], rd_valid <= valid[read_pointer]. If a commit to read_pointer occurs at that same edge, rd_* returns the committing data and rd_valid=1 (bypass). read_pointer >= DEPTH: all rd_* outputs 0.
- clear_en=1 at a posedge: all valid bits cleared; contents retained. A commit at the same edge still applies: its entry ends valid, count=1. Read at the same edge returns pre-clear valid, except the bypassed commit entry.
- count: +1 when commit targets an invalid entry; unchanged when overwriting a valid entry; set per clear rule above. Never exceeds DEPTH.
- Reset (asynchronous): all entries zero, valid all 0, s1_vld=0, count=0, all rd_* = 0. Reset asserted mid-write discards S1 contents; no commit after release.

## Timing
- Write latency: load_en sampled at edge N -> entry committed at edge N+1 -> readable in rd_* after edge N+1 (with bypass, read_pointer held at target during edge N+1).
- Read latency: 1 cycle, read_pointer sampled at edge N, rd_* valid after edge N, held until next edge.
- Throughput: 1 write and 1 read per cycle, simultaneously.
- Result unit is combinational between S1 and the commit edge; a full-width MULT/DIV must close timing in one cycle at the lab clock.
- count updates at the commit edge.

## Test plan
- Reset: hold reset_n=0 for 2 cycles, read all 32 addresses -> rd_* all 0, rd_valid=0, count=0; assert reset_n async between edges -> outputs 0 immediately.
- Write then read: write ptr 5 ADD a=7 b=-3, next cycle read 5 -> rd_result=4, rd_opcode=3, rd_err=0, rd_valid=1, count=1; overwrite ptr 5 with MULT a=-6 b=9 -> result -54, count stays 1.
- Bypass: write ptr 10 SUB a=1 b=5 at edge N, read_pointer=10 at edge N+1 -> rd_result=-4, rd_valid=1 at edge N+1.
- Division: DIV a=-7 b=2 -> -3; MOD a=-7 b=2 -> -1; DIV a=0x80000000 b=-1 -> 2147483648; DIV a=9 b=0 -> result 0, rd_err=1.
- Clear collision: 10 valid entries, clear_en=1 on the same edge as commit to ptr 3 -> count=1, only entry 3 reads rd_valid=1; old data still present at other addresses with rd_valid=0.
- Parameters: DEPTH=20, OP_W=8: write ptr 25 -> dropped, count unchanged; read ptr 25 -> all 0; MULT a=-128 b=-128 -> 16384 in 16-bit rd_result.

Source files
------------

// File: rtl/instr_register_alu_if.sv
// Bus bundle for instr_register_alu: write request, read address and registered read data.
// The bench drives the master side; the register file is the slave.
interface instr_register_alu_if #(
  parameter int OP_W  = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic              load_en;
  logic              clear_en;
  logic [2:0]        opcode;
  logic [OP_W-1:0]   operand_a;
  logic [OP_W-1:0]   operand_b;
  logic [AW-1:0]     write_pointer;
  logic [AW-1:0]     read_pointer;
  logic [2:0]        rd_opcode;
  logic [OP_W-1:0]   rd_op_a;
  logic [OP_W-1:0]   rd_op_b;
  logic [2*OP_W-1:0] rd_result;
  logic              rd_err;
  logic              rd_valid;
  logic [AW:0]       count;

  // No backpressure: load_en is a one-cycle valid sampled at posedge and the entry
  // commits on the next edge; rd_* always reflect read_pointer from the previous edge.
  modport master (
    output load_en, clear_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
    input  rd_opcode, rd_op_a, rd_op_b, rd_result, rd_err, rd_valid, count
  );

  modport slave (
    input  load_en, clear_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
    output rd_opcode, rd_op_a, rd_op_b, rd_result, rd_err, rd_valid, count
  );
endinterface

// File: rtl/instr_register_alu.sv
// Instruction register file with a one-stage result unit: writes are captured in S1,
// the result is computed combinationally and committed with a valid bit on the next edge.
module instr_register_alu #(
  parameter int OP_W  = 32,
  parameter int DEPTH = 32
) (
  input logic               clk,
  input logic               reset_n,
  instr_register_alu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * OP_W;

  typedef enum logic [2:0] {
    OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
  } opcode_e;

  logic            s1_vld;
  logic [2:0]      s1_opc;
  logic [OP_W-1:0] s1_a;
  logic [OP_W-1:0] s1_b;
  logic [AW-1:0]   s1_ptr;

  logic signed [RW-1:0] a_x;
  logic signed [RW-1:0] b_x;
  logic signed [RW-1:0] res;
  logic                 err;

  logic [2:0]      mem_opc [DEPTH];
  logic [OP_W-1:0] mem_a   [DEPTH];
  logic [OP_W-1:0] mem_b   [DEPTH];
  logic [RW-1:0]   mem_res [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [DEPTH-1:0] valid;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;

  logic wr_in_range;
  logic rd_in_range;
  logic rd_hit;

  assign wr_in_range = {1'b0, bus.write_pointer} < (AW+1)'(DEPTH);
  assign rd_in_range = {1'b0, bus.read_pointer} < (AW+1)'(DEPTH);
  assign rd_hit      = s1_vld && (s1_ptr == bus.read_pointer);
  assign bus.count   = count;

  // Out-of-range writes never raise s1_vld, so s1_ptr is always a legal index when it matters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_opc <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_ptr <= '0;
    end else begin
      s1_vld <= bus.load_en && wr_in_range;
      if (bus.load_en) begin
        s1_opc <= bus.opcode;
        s1_a   <= bus.operand_a;
        s1_b   <= bus.operand_b;
        s1_ptr <= bus.write_pointer;
      end
    end
  end

  // Operands are widened first so MULT and min/-1 DIV cannot overflow.
  always_comb begin
    a_x = {{OP_W{s1_a[OP_W-1]}}, s1_a};
    b_x = {{OP_W{s1_b[OP_W-1]}}, s1_b};
    res = '0;
    err = 1'b0;
    case (opcode_e'(s1_opc))
      OP_ZERO:  res = '0;
      OP_PASSA: res = a_x;
      OP_PASSB: res = b_x;
      OP_ADD:   res = a_x + b_x;
      OP_SUB:   res = a_x - b_x;
      OP_MULT:  res = a_x * b_x;
      OP_DIV: begin
        if (s1_b == '0) err = 1'b1;
        else            res = a_x / b_x;
      end
      OP_MOD: begin
        if (s1_b == '0) err = 1'b1;
        else            res = a_x % b_x;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (bus.clear_en)                 count_nxt = (AW+1)'(s1_vld);
    else if (s1_vld && !valid[s1_ptr]) count_nxt = count + (AW+1)'(1);
  end

  // Clear wipes valid first; a same-edge commit then re-marks its own entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_opc[i] <= '0;
        mem_a[i]   <= '0;
        mem_b[i]   <= '0;
        mem_res[i] <= '0;
      end
      mem_err <= '0;
      valid   <= '0;
      count   <= '0;
    end else begin
      if (bus.clear_en) valid <= '0;
      if (s1_vld) begin
        mem_opc[s1_ptr] <= s1_opc;
        mem_a[s1_ptr]   <= s1_a;
        mem_b[s1_ptr]   <= s1_b;
        mem_res[s1_ptr] <= res;
        mem_err[s1_ptr] <= err;
        valid[s1_ptr]   <= 1'b1;
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !rd_in_range) begin
      bus.rd_opcode <= '0;
      bus.rd_op_a   <= '0;
      bus.rd_op_b   <= '0;
      bus.rd_result <= '0;
      bus.rd_err    <= 1'b0;
      bus.rd_valid  <= 1'b0;
    end else if (rd_hit) begin
      bus.rd_opcode <= s1_opc;
      bus.rd_op_a   <= s1_a;
      bus.rd_op_b   <= s1_b;
      bus.rd_result <= res;
      bus.rd_err    <= err;
      bus.rd_valid  <= 1'b1;
    end else begin
      bus.rd_opcode <= mem_opc[bus.read_pointer];
      bus.rd_op_a   <= mem_a[bus.read_pointer];
      bus.rd_op_b   <= mem_b[bus.read_pointer];
      bus.rd_result <= mem_res[bus.read_pointer];
      bus.rd_err    <= mem_err[bus.read_pointer];
      bus.rd_valid  <= valid[bus.read_pointer];
    end
  end
endmodule
